// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter.
//   N_REQ_DEFAULT : default requester count (matches the 4-bit one-hot encoder input)
//   PTR_W         : width of the round-robin pointer / winner index
//   arb_state_e   : FSM state encodings (StIdle, StGrant)
package rr_arbiter_pkg;

    localparam int unsigned N_REQ_DEFAULT = 4;
    localparam int unsigned PTR_W         = $clog2(N_REQ_DEFAULT);

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin winner selection.
// Search starts at i_ptr+1 (mod N_REQ); the first set request bit wins.
//   i_req   : request vector
//   i_ptr   : index of the last released winner
//   o_grant : one-hot winner (all-zero if no request)
//   o_idx   : winner index (0 if no request)
module rr_arbiter_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PtrW  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PtrW-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PtrW-1:0]  o_idx
);

    logic            w_found;
    int unsigned     w_pos;
    logic [PtrW-1:0] w_sel;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_sel   = '0;
        // k = 1 first so the last winner is considered only after everyone else.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_pos = (32'(i_ptr) + k) % N_REQ;
            w_sel = PtrW'(w_pos);
            if (!w_found && i_req[w_sel]) begin
                w_found        = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a held, registered one-hot grant.
// Optional feature macro: RR_ARBITER_BACK_TO_BACK_EN -- when defined, an ack with
// pending requests (and arbiter_en=1) regrants on the same edge with no idle bubble.
//   clk           : clock, rising edge
//   reset_n       : asynchronous active-low reset
//   arbiter_en    : allows a new grant to be issued
//   arbiter_req   : request vector
//   arbiter_ack   : releases the current grant
//   arbiter_grant : registered one-hot grant, zero when idle
//   arbiter_valid : registered, OR of arbiter_grant
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             arbiter_en,
    input  logic [N_REQ-1:0] arbiter_req,
    input  logic             arbiter_ack,
    output logic [N_REQ-1:0] arbiter_grant,
    output logic             arbiter_valid
);

    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PtrW-1:0] PtrRst = PtrW'(N_REQ - 1);

    arb_state_e       r_state, w_state_d;
    logic [N_REQ-1:0] r_grant, w_grant_d;
    logic             r_valid;
    logic [PtrW-1:0]  r_ptr, w_ptr_d;
    logic [PtrW-1:0]  r_win, w_win_d;

    logic [PtrW-1:0]  w_pick_ptr;
    logic [N_REQ-1:0] w_pick_grant;
    logic [PtrW-1:0]  w_pick_idx;
    logic             w_start;

    // While granted, r_win becomes the pointer on ack, so search from it; this lets a
    // back-to-back regrant use the post-ack pointer without waiting a cycle.
    assign w_pick_ptr = (r_state == StGrant) ? r_win : r_ptr;
    assign w_start    = arbiter_en && (|arbiter_req);

    rr_arbiter_pick #(
        .N_REQ (N_REQ),
        .PtrW  (PtrW)
    ) u_pick (
        .i_req   (arbiter_req),
        .i_ptr   (w_pick_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_ptr   <= PtrRst;
            r_win   <= PtrRst;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_valid <= |w_grant_d;
            r_ptr   <= w_ptr_d;
            r_win   <= w_win_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_ptr_d   = r_ptr;
        w_win_d   = r_win;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_d = StGrant;
                    w_grant_d = w_pick_grant;
                    w_win_d   = w_pick_idx;
                end
            end
            StGrant: begin
                if (arbiter_ack) begin
                    w_ptr_d = r_win;
`ifdef RR_ARBITER_BACK_TO_BACK_EN
                    if (w_start) begin
                        w_grant_d = w_pick_grant;
                        w_win_d   = w_pick_idx;
                    end else begin
                        w_state_d = StIdle;
                        w_grant_d = '0;
                    end
`else
                    w_state_d = StIdle;
                    w_grant_d = '0;
`endif
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        arbiter_grant = r_grant;
        arbiter_valid = r_valid;
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: table-driven vectors plus hand sequences for
// round-robin rotation, hold/release, wrap-around and asynchronous reset.
module tb_rr_arbiter;
    import rr_arbiter_pkg::*;

    localparam int unsigned N = N_REQ_DEFAULT;

    logic         clk;
    logic         reset_n;
    logic         arbiter_en;
    logic [N-1:0] arbiter_req;
    logic         arbiter_ack;
    logic [N-1:0] arbiter_grant;
    logic         arbiter_valid;

    int n_checks;
    int n_fail;

    rr_arbiter #(
        .N_REQ (N)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .arbiter_en    (arbiter_en),
        .arbiter_req   (arbiter_req),
        .arbiter_ack   (arbiter_ack),
        .arbiter_grant (arbiter_grant),
        .arbiter_valid (arbiter_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         en;
        logic [N-1:0] req;
        logic         ack;
        logic [N-1:0] exp_grant;
        logic         exp_valid;
        string        name;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [N-1:0] exp_g, input logic exp_v);
        n_checks++;
        if (arbiter_grant !== exp_g || arbiter_valid !== exp_v || !$onehot0(arbiter_grant)) begin
            n_fail++;
            $display("FAIL %s: grant=%b valid=%b, required grant=%b valid=%b",
                     name, arbiter_grant, arbiter_valid, exp_g, exp_v);
        end
    endtask

    // Drive inputs on the falling edge, then step to just after the next rising edge.
    task automatic drive(input logic rst, input logic en, input logic [N-1:0] req,
                         input logic ack);
        @(negedge clk);
        reset_n     = rst;
        arbiter_en  = en;
        arbiter_req = req;
        arbiter_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic step_check(input string name, input logic rst, input logic en,
                              input logic [N-1:0] req, input logic ack,
                              input logic [N-1:0] exp_g);
        drive(rst, en, req, ack);
        check(name, exp_g, |exp_g);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        arbiter_en  = 1'b0;
        arbiter_req = '0;
        arbiter_ack = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, "reset"};
        vecs[1]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, "first_grant"};
        vecs[2]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, "hold1"};
        vecs[3]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, "hold2"};
        vecs[4]  = '{1'b1, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, "hold3"};
        vecs[5]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "ack_release"};
        vecs[6]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, "ack_in_idle"};
        vecs[7]  = '{1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, "en_low_no_grant"};
        vecs[8]  = '{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0010, 1'b1, "rr_after_0"};
        vecs[9]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b1, "hold_req_en_low"};
        vecs[10] = '{1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "ack_en_low"};
        vecs[11] = '{1'b1, 1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, "single_req_wins"};
        vecs[12] = '{1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, "single_release"};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].req, vecs[i].ack);
            check(vecs[i].name, vecs[i].exp_grant, vecs[i].exp_valid);
        end

        // Full contention rotation, ack pulsed on each grant.
        step_check("rot_reset", 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
        step_check("rot_g0", 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0001);
`ifdef RR_ARBITER_BACK_TO_BACK_EN
        step_check("b2b_g1", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010);
        step_check("b2b_g2", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100);
        step_check("b2b_g3", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000);
        step_check("b2b_g0", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001);
`else
        step_check("rot_bubble0", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000);
        step_check("rot_g1", 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0010);
        step_check("rot_bubble1", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000);
        step_check("rot_g2", 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0100);
        step_check("rot_bubble2", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000);
        step_check("rot_g3", 1'b1, 1'b1, 4'b1111, 1'b0, 4'b1000);
        step_check("rot_bubble3", 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0000);
        step_check("rot_g0_again", 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0001);
`endif

        // Hold while winner drops and en drops; release with en=0 grants nothing.
        step_check("hold_reset", 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
        step_check("hold_g2", 1'b1, 1'b1, 4'b0100, 1'b0, 4'b0100);
        step_check("hold_drop1", 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0100);
        step_check("hold_drop2", 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0100);
        step_check("hold_ack_en0", 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000);
        step_check("hold_no_new", 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0000);

        // Wrap and skip: last winner 3, req=1010 -> 1 then 3.
        step_check("wrap_g3", 1'b1, 1'b1, 4'b1000, 1'b0, 4'b1000);
        step_check("wrap_rel3", 1'b1, 1'b1, 4'b0000, 1'b1, 4'b0000);
        step_check("wrap_g1", 1'b1, 1'b1, 4'b1010, 1'b0, 4'b0010);
`ifdef RR_ARBITER_BACK_TO_BACK_EN
        step_check("wrap_skip_g3", 1'b1, 1'b1, 4'b1010, 1'b1, 4'b1000);
`else
        step_check("wrap_bubble", 1'b1, 1'b1, 4'b1010, 1'b1, 4'b0000);
        step_check("wrap_skip_g3", 1'b1, 1'b1, 4'b1010, 1'b0, 4'b1000);
`endif

        // Asynchronous reset mid-grant, then restart from requester 0.
        step_check("pre_rst_hold", 1'b1, 1'b1, 4'b1111, 1'b0, 4'b1000);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 4'b0000, 1'b0);
        step_check("in_reset_edge", 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000);
        step_check("post_reset_g0", 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; the default matches the 4-bit one-hot input of the downstream encoder; only 4 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 arbiter_en  input  1  when 0, no new grant is issued; an existing grant is unaffected.
REQ-005 arbiter_req  input  N_REQ  request vector, bit i = requester i.
REQ-006 arbiter_ack  input  1  consumer done; releases the current grant.
REQ-007 arbiter_grant  output  N_REQ  registered one-hot grant, all-zero when idle; drives the encoder input.
REQ-008 arbiter_valid  output  1  registered; equals OR of arbiter_grant.

Function
REQ-009 The FSM SHALL have two states: IDLE (grant = 0) and GRANT (grant one-hot, held).
REQ-010 IDLE -> GRANT on a rising edge when arbiter_en=1 and arbiter_req!=0; grant SHALL appear one cycle after req is sampled.
REQ-011 Winner selection SHALL be round-robin: search order starts at ptr+1 modulo N_REQ, where ptr = index of the last released winner; the first set req bit in that order wins.
REQ-012 In GRANT, the grant SHALL be held unchanged until arbiter_ack=1, even if the winner's req drops or arbiter_en drops.
REQ-013 On ack in GRANT: ptr <= winner index; grant cleared; next state IDLE (one-cycle bubble) unless the REQ-021 option is active.
REQ-014 arbiter_ack in IDLE SHALL be ignored (no state or ptr change).
REQ-015 ptr wrap-around: winner 3 -> search starts at 0.
REQ-016 Only one requester active: it SHALL win every round regardless of ptr.
REQ-017 Grant SHALL never have more than one bit set; valid and grant SHALL change on the same edge.

Reset
REQ-018 reset_n=0 SHALL immediately force grant=0, valid=0, state=IDLE, and ptr=N_REQ-1 (so requester 0 has first priority).
REQ-019 Reset asserted mid-GRANT SHALL drop the grant without requiring ack; after release, arbitration restarts from REQ-018 values.
REQ-020 The first grant after reset release is no earlier than the first rising edge with reset_n=1.

Configuration
REQ-021 Macro RR_ARBITER_BACK_TO_BACK_EN defined: on ack, if arbiter_en=1 and the req vector has a bit set, the next winner (search from new ptr) SHALL be granted on the same edge, staying in GRANT with no bubble; valid stays 1.
REQ-022 Macro undefined: ack always returns to IDLE for exactly one cycle, per REQ-013.

Structure
REQ-023 The shared package header (included by the arbiter and bench) SHALL hold the N_REQ default, the state encodings IDLE/GRANT, and the ptr width constant.
REQ-024 Selection logic SHALL be one combinational sub-module rr_arbiter_pick (inputs req, ptr; outputs one-hot winner and winner index); the top holds only the FSM and registers.

Verification
REQ-025 Reset, then req=0001, en=1 -> grant=0001 and valid=1 on the next edge; holds through 3 cycles without ack.
REQ-026 req=1111 held, ack pulsed each grant, macro off -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-027 Same stimulus, macro on -> grant sequence 0001,0010,0100,1000,0001 with valid never dropping.
REQ-028 Grant=0100, winner drops req, en=0 -> grant stays 0100 until ack; after ack with en=0 -> grant=0000 and no new grant.
REQ-029 req=1010 after the last winner 3 -> grant=0010; after ack, grant=1000 (wrap and skip).
REQ-030 reset_n pulsed low mid-GRANT (grant=1000) -> grant=0000 asynchronously; with req=1111 after release, first grant=0001.
